// File: rtl/phase_sweep_nco_if.sv
// Config channel and sample bus between the sweep NCO and its controller / CORDIC consumer.
interface phase_sweep_nco_if #(
  parameter int ACC_W   = 24,
  parameter int ANGLE_W = 12,
  parameter int DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic               cfg_phase_rst;
  logic [ACC_W-1:0]   cfg_f0;
  logic [ACC_W-1:0]   cfg_f1;
  logic [ACC_W-1:0]   cfg_rate;
  logic [DWELL_W-1:0] cfg_dwell;

  logic [ANGLE_W:0]   angle_o;
  logic [1:0]         quarter_o;
  logic               valid_o;
  logic               wrap_o;
  logic               sweep_done_o;
  logic [ACC_W-1:0]   freq_o;

  modport master (
    output cfg_valid, cfg_mode, cfg_phase_rst, cfg_f0, cfg_f1, cfg_rate, cfg_dwell,
    input  cfg_ready, angle_o, quarter_o, valid_o, wrap_o, sweep_done_o, freq_o
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_phase_rst, cfg_f0, cfg_f1, cfg_rate, cfg_dwell,
    output cfg_ready, angle_o, quarter_o, valid_o, wrap_o, sweep_done_o, freq_o
  );
endinterface

// File: rtl/phase_sweep_nco.sv
// Phase accumulator producing quarter-split angles for the CORDIC stage,
// with fixed-tone or sawtooth chirp tuning and phase-continuous retune.
module phase_sweep_nco #(
  parameter int ACC_W   = 24,
  parameter int ANGLE_W = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  phase_sweep_nco_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FIXED, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [ACC_W-1:0]   freq, freq_nxt;
  logic [DWELL_W-1:0] dwell_cnt, cnt_nxt;
  logic               valid, valid_nxt;
  logic               wrap, wrap_nxt;
  logic               done, done_nxt;
  logic               ready;
  logic [ACC_W-1:0]   f0, f1, rate;
  logic [DWELL_W-1:0] dwell;
  logic [ACC_W:0]     acc_sum, step_sum;
  logic               accept, run;

  assign accept   = bus.cfg_valid && ready;
  assign run      = (state != IDLE) && en;
  assign acc_sum  = {1'b0, acc} + {1'b0, freq};
  assign step_sum = {1'b0, freq} + {1'b0, rate};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    freq_nxt  = freq;
    cnt_nxt   = dwell_cnt;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;

    if (run) begin
      acc_nxt   = acc_sum[ACC_W-1:0];
      wrap_nxt  = acc_sum[ACC_W];
      valid_nxt = 1'b1;
    end

    // An inverted range (f1 < f0) never steps, so the sweep degenerates to a fixed tone.
    if (run && state == SWEEP) begin
      if (dwell_cnt == dwell) begin
        cnt_nxt = '0;
        if (f1 >= f0) begin
          if (step_sum > {1'b0, f1}) begin
            freq_nxt = f0;
            done_nxt = 1'b1;
          end else begin
            freq_nxt = step_sum[ACC_W-1:0];
          end
        end
      end else begin
        cnt_nxt = dwell_cnt + DWELL_W'(1);
      end
    end

    // New config wins over stepping; the accumulate above still used the old freq.
    if (accept) begin
      cnt_nxt  = '0;
      done_nxt = 1'b0;
      case (bus.cfg_mode)
        2'b01: begin
          state_nxt = FIXED;
          freq_nxt  = bus.cfg_f0;
        end
        2'b10: begin
          state_nxt = SWEEP;
          freq_nxt  = bus.cfg_f0;
        end
        default: state_nxt = IDLE;
      endcase
      if (bus.cfg_phase_rst) begin
        acc_nxt   = '0;
        wrap_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      freq      <= '0;
      dwell_cnt <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b0;
      f0        <= '0;
      f1        <= '0;
      rate      <= '0;
      dwell     <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      freq      <= freq_nxt;
      dwell_cnt <= cnt_nxt;
      valid     <= valid_nxt;
      wrap      <= wrap_nxt;
      done      <= done_nxt;
      ready     <= 1'b1;
      if (accept) begin
        f0    <= bus.cfg_f0;
        f1    <= bus.cfg_f1;
        rate  <= bus.cfg_rate;
        dwell <= bus.cfg_dwell;
      end
    end
  end

  assign bus.angle_o      = {1'b0, acc[ACC_W-3 -: ANGLE_W]};
  assign bus.quarter_o    = acc[ACC_W-1 -: 2];
  assign bus.valid_o      = valid;
  assign bus.wrap_o       = wrap;
  assign bus.sweep_done_o = done;
  assign bus.freq_o       = freq;
  assign bus.cfg_ready    = ready;

endmodule
